// File: rtl/l1_beat_bus_interface_if.sv
// Signal bundle for l1_beat_bus_interface: controller/snooper requests, outgoing
// bus beats and incoming fill beats. The block itself connects through the master modport.
interface l1_beat_bus_interface_if #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned ADDRESS_BITS      = 32,
    parameter int unsigned MSG_BITS          = 4,
    parameter int unsigned CACHE_OFFSET_BITS = 2,
    parameter int unsigned BUS_OFFSET_BITS   = 0
);
    localparam int unsigned CACHE_WIDTH = DATA_WIDTH << CACHE_OFFSET_BITS;
    localparam int unsigned BUS_WIDTH   = DATA_WIDTH << BUS_OFFSET_BITS;
    localparam int unsigned BW          = CACHE_OFFSET_BITS - BUS_OFFSET_BITS + 1;

    logic                    cache_valid_in;
    logic [MSG_BITS-1:0]     cache_msg_in;
    logic [ADDRESS_BITS-1:0] cache_address_in;
    logic [CACHE_WIDTH-1:0]  cache_data_in;
    logic                    cache_ready_out;

    logic                    snoop_valid_in;
    logic [MSG_BITS-1:0]     snoop_msg_in;
    logic [ADDRESS_BITS-1:0] snoop_address_in;
    logic [CACHE_WIDTH-1:0]  snoop_data_in;
    logic                    snoop_ready_out;

    logic                    bus_grant;
    logic                    bus_beat_ack;
    logic                    bus_valid_out;
    logic [MSG_BITS-1:0]     bus_msg_out;
    logic [ADDRESS_BITS-1:0] bus_address_out;
    logic [BUS_WIDTH-1:0]    bus_data_out;
    logic [BW-1:0]           active_offset;
    logic                    send_done;

    logic                    bus_beat_valid_in;
    logic [BUS_WIDTH-1:0]    bus_data_in;
    logic [CACHE_WIDTH-1:0]  line_data_out;
    logic                    line_valid_out;

    modport master (
        input  cache_valid_in, cache_msg_in, cache_address_in, cache_data_in,
        output cache_ready_out,
        input  snoop_valid_in, snoop_msg_in, snoop_address_in, snoop_data_in,
        output snoop_ready_out,
        input  bus_grant, bus_beat_ack,
        output bus_valid_out, bus_msg_out, bus_address_out, bus_data_out,
        output active_offset, send_done,
        input  bus_beat_valid_in, bus_data_in,
        output line_data_out, line_valid_out
    );

    modport slave (
        output cache_valid_in, cache_msg_in, cache_address_in, cache_data_in,
        input  cache_ready_out,
        output snoop_valid_in, snoop_msg_in, snoop_address_in, snoop_data_in,
        input  snoop_ready_out,
        output bus_grant, bus_beat_ack,
        input  bus_valid_out, bus_msg_out, bus_address_out, bus_data_out,
        input  active_offset, send_done,
        output bus_beat_valid_in, bus_data_in,
        input  line_data_out, line_valid_out
    );
endinterface

// File: rtl/l1_beat_bus_interface.sv
// Splits a cache line into bus beats for controller/snooper requests and,
// independently, reassembles incoming fill beats into whole lines.
module l1_beat_bus_interface #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned ADDRESS_BITS      = 32,
    parameter int unsigned MSG_BITS          = 4,
    parameter int unsigned CACHE_OFFSET_BITS = 2,
    parameter int unsigned BUS_OFFSET_BITS   = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    l1_beat_bus_interface_if.master        bus_if
);
    localparam int unsigned CACHE_WIDTH = DATA_WIDTH << CACHE_OFFSET_BITS;
    localparam int unsigned BUS_WIDTH   = DATA_WIDTH << BUS_OFFSET_BITS;
    localparam int unsigned BEATS       = 1 << (CACHE_OFFSET_BITS - BUS_OFFSET_BITS);
    localparam int unsigned BW          = CACHE_OFFSET_BITS - BUS_OFFSET_BITS + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [ADDRESS_BITS-1:0] BASE_MASK = ~ADDRESS_BITS'((1 << CACHE_OFFSET_BITS) - 1);

    if (BUS_OFFSET_BITS > CACHE_OFFSET_BITS) begin : g_bad_cfg
        $error("BUS_OFFSET_BITS must not exceed CACHE_OFFSET_BITS");
    end

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

    state_e                  state_q, state_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [MSG_BITS-1:0]     msg_q, msg_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [CACHE_WIDTH-1:0]  line_q, line_d;
    logic [BW-1:0]           fcnt_q, fcnt_d;
    logic [CACHE_WIDTH-1:0]  fill_q, fill_d;
    logic [CACHE_WIDTH-1:0]  fill_line_q, fill_line_d;
    logic                    line_valid_q, line_valid_d;
    logic                    snoop_accept, cache_accept, beat_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            msg_q        <= '0;
            addr_q       <= '0;
            line_q       <= '0;
            fcnt_q       <= '0;
            fill_q       <= '0;
            fill_line_q  <= '0;
            line_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            msg_q        <= msg_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            fcnt_q       <= fcnt_d;
            fill_q       <= fill_d;
            fill_line_q  <= fill_line_d;
            line_valid_q <= line_valid_d;
        end
    end

    // Send FSM next state; snoop responses win over controller requests.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        msg_d        = msg_q;
        addr_d       = addr_q;
        line_d       = line_q;
        snoop_accept = 1'b0;
        cache_accept = 1'b0;
        beat_done    = bus_if.bus_grant && bus_if.bus_beat_ack;
        unique case (state_q)
            IDLE: begin
                snoop_accept = bus_if.snoop_valid_in;
                cache_accept = !bus_if.snoop_valid_in && bus_if.cache_valid_in;
                if (snoop_accept) begin
                    msg_d   = bus_if.snoop_msg_in;
                    addr_d  = bus_if.snoop_address_in & BASE_MASK;
                    line_d  = bus_if.snoop_data_in;
                    beat_d  = '0;
                    state_d = SEND;
                end else if (cache_accept) begin
                    msg_d   = bus_if.cache_msg_in;
                    addr_d  = bus_if.cache_address_in & BASE_MASK;
                    line_d  = bus_if.cache_data_in;
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beat_done) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fill assembly: the completed line is merged with the final beat in the same cycle.
    always_comb begin
        fcnt_d       = fcnt_q;
        fill_d       = fill_q;
        fill_line_d  = fill_line_q;
        line_valid_d = 1'b0;
        if (bus_if.bus_beat_valid_in) begin
            fill_d[fcnt_q*BUS_WIDTH +: BUS_WIDTH] = bus_if.bus_data_in;
            if (fcnt_q == LAST_BEAT) begin
                fcnt_d       = '0;
                fill_line_d  = fill_d;
                line_valid_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Ready outputs are gated by reset so every output reads 0 while it is held.
    always_comb begin
        bus_if.cache_ready_out = cache_accept && reset;
        bus_if.snoop_ready_out = snoop_accept && reset;
        bus_if.bus_valid_out   = 1'b0;
        bus_if.bus_msg_out     = '0;
        bus_if.bus_address_out = '0;
        bus_if.bus_data_out    = '0;
        bus_if.active_offset   = '0;
        bus_if.send_done       = (state_q == DONE);
        bus_if.line_data_out   = fill_line_q;
        bus_if.line_valid_out  = line_valid_q;
        if (state_q == SEND) begin
            bus_if.bus_valid_out   = bus_if.bus_grant;
            bus_if.bus_msg_out     = msg_q;
            bus_if.bus_address_out = addr_q | (ADDRESS_BITS'(beat_q) << BUS_OFFSET_BITS);
            bus_if.bus_data_out    = line_q[beat_q*BUS_WIDTH +: BUS_WIDTH];
            bus_if.active_offset   = beat_q;
        end
    end
endmodule

// File: tb/tb_l1_beat_bus_interface.sv
// Bench for l1_beat_bus_interface: a 4-beat instance and a single-beat instance,
// with scoreboards for sent beats and assembled fill lines.
module tb_l1_beat_bus_interface;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    l1_beat_bus_interface_if #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .MSG_BITS(4),
        .CACHE_OFFSET_BITS(2), .BUS_OFFSET_BITS(0)) i0 ();
    l1_beat_bus_interface #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .MSG_BITS(4),
        .CACHE_OFFSET_BITS(2), .BUS_OFFSET_BITS(0)) u0 (.clock(clock), .reset(reset), .bus_if(i0));

    l1_beat_bus_interface_if #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .MSG_BITS(4),
        .CACHE_OFFSET_BITS(2), .BUS_OFFSET_BITS(2)) i1 ();
    l1_beat_bus_interface #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .MSG_BITS(4),
        .CACHE_OFFSET_BITS(2), .BUS_OFFSET_BITS(2)) u1 (.clock(clock), .reset(reset), .bus_if(i1));

    typedef struct {
        logic [3:0]   msg;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [2:0]   off;
    } beat_t;

    typedef struct {
        bit           snoop;
        logic [3:0]   msg;
        logic [31:0]  addr;
        logic [127:0] line;
        int           exp_lat;
    } req_t;

    beat_t        q0[$];
    beat_t        q1[$];
    logic [127:0] f0[$];
    logic [127:0] f1[$];
    beat_t        e0, e1;
    logic [127:0] el0, el1;
    req_t         vec[5];
    int           lat, lat_f;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push0(input logic [3:0] msg, input logic [31:0] addr, input logic [127:0] line);
        logic [31:0] base;
        base = addr & 32'hFFFF_FFFC;
        for (int k = 0; k < 4; k++) begin
            beat_t b;
            b.msg  = msg;
            b.addr = base | 32'(k);
            b.data = {96'b0, line[k*32 +: 32]};
            b.off  = 3'(k);
            q0.push_back(b);
        end
    endtask

    task automatic push1(input logic [3:0] msg, input logic [31:0] addr, input logic [127:0] line);
        beat_t b;
        b.msg  = msg;
        b.addr = addr & 32'hFFFF_FFFC;
        b.data = line;
        b.off  = 3'd0;
        q1.push_back(b);
    endtask

    task automatic req0(input bit snoop, input logic [3:0] msg, input logic [31:0] addr,
                        input logic [127:0] line);
        @(posedge clock); #1;
        if (snoop) begin
            i0.snoop_valid_in = 1'b1; i0.snoop_msg_in = msg;
            i0.snoop_address_in = addr; i0.snoop_data_in = line;
        end else begin
            i0.cache_valid_in = 1'b1; i0.cache_msg_in = msg;
            i0.cache_address_in = addr; i0.cache_data_in = line;
        end
        push0(msg, addr, line);
        @(negedge clock);
        if (snoop) check("snoop_ready", {127'b0, i0.snoop_ready_out}, 128'd1);
        else       check("cache_ready", {127'b0, i0.cache_ready_out}, 128'd1);
        @(posedge clock); #1;
        i0.snoop_valid_in = 1'b0;
        i0.cache_valid_in = 1'b0;
    endtask

    task automatic wait_done0(output int l);
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            if (i0.send_done) begin
                l = n;
                return;
            end
        end
        l = -1;
    endtask

    task automatic fill0(input logic [31:0] d, input int gap);
        repeat (gap) @(posedge clock);
        @(posedge clock); #1;
        i0.bus_beat_valid_in = 1'b1;
        i0.bus_data_in = d;
        @(posedge clock); #1;
        i0.bus_beat_valid_in = 1'b0;
    endtask

    // Scoreboard monitors: every acked beat and every completed line must be expected.
    always @(negedge clock) begin
        if (i0.bus_valid_out && i0.bus_beat_ack) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_beat: got addr %0h, expected no beat", i0.bus_address_out);
            end else begin
                e0 = q0.pop_front();
                check("dut0_beat_msg",  {124'b0, i0.bus_msg_out}, {124'b0, e0.msg});
                check("dut0_beat_addr", {96'b0, i0.bus_address_out}, {96'b0, e0.addr});
                check("dut0_beat_data", {96'b0, i0.bus_data_out}, e0.data);
                check("dut0_beat_off",  {125'b0, i0.active_offset}, {125'b0, e0.off});
            end
        end
        if (i0.line_valid_out) begin
            if (f0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_line: got %0h, expected no line", i0.line_data_out);
            end else begin
                el0 = f0.pop_front();
                check("dut0_fill_line", i0.line_data_out, el0);
            end
        end
        if (i1.bus_valid_out && i1.bus_beat_ack) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_beat: got addr %0h, expected no beat", i1.bus_address_out);
            end else begin
                e1 = q1.pop_front();
                check("dut1_beat_msg",  {124'b0, i1.bus_msg_out}, {124'b0, e1.msg});
                check("dut1_beat_addr", {96'b0, i1.bus_address_out}, {96'b0, e1.addr});
                check("dut1_beat_data", i1.bus_data_out, e1.data);
                check("dut1_beat_off",  {127'b0, i1.active_offset}, {125'b0, e1.off});
            end
        end
        if (i1.line_valid_out) begin
            if (f1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_line: got %0h, expected no line", i1.line_data_out);
            end else begin
                el1 = f1.pop_front();
                check("dut1_fill_line", i1.line_data_out, el1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{1'b0, 4'h3, 32'h0000_0104, 128'h000000D3_000000D2_000000D1_000000D0, 4};
        vec[1] = '{1'b1, 4'h5, 32'h0000_0107, 128'h33333333_22222222_11111111_00000000, 4};
        vec[2] = '{1'b0, 4'hF, 32'hFFFF_FFFF, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 4};
        vec[3] = '{1'b1, 4'h1, 32'h0000_0000, {128{1'b1}}, 4};
        vec[4] = '{1'b0, 4'h2, 32'h8000_0002, 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F, 4};

        reset = 1'b0;
        i0.cache_valid_in = 1'b1; i0.cache_msg_in = '0; i0.cache_address_in = '0; i0.cache_data_in = '0;
        i0.snoop_valid_in = 1'b1; i0.snoop_msg_in = '0; i0.snoop_address_in = '0; i0.snoop_data_in = '0;
        i0.bus_grant = 1'b1; i0.bus_beat_ack = 1'b1;
        i0.bus_beat_valid_in = 1'b0; i0.bus_data_in = '0;
        i1.cache_valid_in = 1'b0; i1.cache_msg_in = '0; i1.cache_address_in = '0; i1.cache_data_in = '0;
        i1.snoop_valid_in = 1'b0; i1.snoop_msg_in = '0; i1.snoop_address_in = '0; i1.snoop_data_in = '0;
        i1.bus_grant = 1'b1; i1.bus_beat_ack = 1'b0;
        i1.bus_beat_valid_in = 1'b0; i1.bus_data_in = '0;

        #22;
        check("rst_snoop_ready", {127'b0, i0.snoop_ready_out}, 128'd0);
        check("rst_cache_ready", {127'b0, i0.cache_ready_out}, 128'd0);
        check("rst_bus_valid",   {127'b0, i0.bus_valid_out}, 128'd0);
        check("rst_bus_addr",    {96'b0, i0.bus_address_out}, 128'd0);
        check("rst_send_done",   {127'b0, i0.send_done}, 128'd0);
        check("rst_line_valid",  {127'b0, i0.line_valid_out}, 128'd0);
        check("rst_line_data",   i0.line_data_out, 128'd0);
        i0.cache_valid_in = 1'b0;
        i0.snoop_valid_in = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Table of single requests with grant and ack held high.
        foreach (vec[i]) begin
            req0(vec[i].snoop, vec[i].msg, vec[i].addr, vec[i].line);
            wait_done0(lat);
            check("table_done_latency", 128'(lat), 128'(vec[i].exp_lat));
            check("table_queue_empty", 128'(q0.size()), 128'd0);
        end

        // Simultaneous snoop and cache requests: snoop first, cache after send_done.
        @(posedge clock); #1;
        i0.snoop_valid_in = 1'b1; i0.snoop_msg_in = 4'h6;
        i0.snoop_address_in = 32'h208; i0.snoop_data_in = 128'h5D5D5D5D_5C5C5C5C_5B5B5B5B_5A5A5A5A;
        i0.cache_valid_in = 1'b1; i0.cache_msg_in = 4'h7;
        i0.cache_address_in = 32'h30C; i0.cache_data_in = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
        push0(4'h6, 32'h208, 128'h5D5D5D5D_5C5C5C5C_5B5B5B5B_5A5A5A5A);
        push0(4'h7, 32'h30C, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0);
        @(negedge clock);
        check("prio_snoop_ready", {127'b0, i0.snoop_ready_out}, 128'd1);
        check("prio_cache_ready", {127'b0, i0.cache_ready_out}, 128'd0);
        @(posedge clock); #1;
        i0.snoop_valid_in = 1'b0;
        wait_done0(lat);
        check("prio_snoop_latency", 128'(lat), 128'd4);
        check("prio_cache_ready_in_done", {127'b0, i0.cache_ready_out}, 128'd0);
        @(negedge clock);
        check("prio_cache_ready_idle", {127'b0, i0.cache_ready_out}, 128'd1);
        @(posedge clock); #1;
        i0.cache_valid_in = 1'b0;
        wait_done0(lat);
        check("prio_cache_latency", 128'(lat), 128'd4);
        check("prio_queue_empty", 128'(q0.size()), 128'd0);

        // Grant withdrawn on beat 2 for three cycles; ack stays high and is ignored.
        req0(1'b0, 4'h9, 32'h40, 128'h44444444_33333333_22222222_11111111);
        @(posedge clock); #1;
        @(posedge clock); #1;
        i0.bus_grant = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("nogrant_valid",  {127'b0, i0.bus_valid_out}, 128'd0);
            check("nogrant_offset", {125'b0, i0.active_offset}, 128'd2);
            check("nogrant_addr",   {96'b0, i0.bus_address_out}, 128'h42);
        end
        @(posedge clock); #1;
        i0.bus_grant = 1'b1;
        wait_done0(lat);
        check("nogrant_resume_latency", 128'(lat), 128'd2);
        check("nogrant_queue_empty", 128'(q0.size()), 128'd0);

        // Fill with gaps, then a fifth beat opening a new line.
        fill0(32'hA, 0);
        fill0(32'hB, 2);
        fill0(32'hC, 1);
        f0.push_back({32'hD, 32'hC, 32'hB, 32'hA});
        fill0(32'hD, 3);
        repeat (3) @(negedge clock);
        fill0(32'hE, 0);
        repeat (3) @(negedge clock);
        check("fill_hold_line", i0.line_data_out, {32'hD, 32'hC, 32'hB, 32'hA});
        check("fill_queue_after_first", 128'(f0.size()), 128'd0);

        // Send and fill concurrently.
        fork
            begin
                req0(1'b0, 4'h4, 32'h500, 128'h0B0B0B0B_0A0A0A0A_09090909_08080808);
                wait_done0(lat_f);
                check("concurrent_send_latency", 128'(lat_f), 128'd4);
            end
            begin
                fill0(32'hF, 0);
                fill0(32'h10, 1);
                f0.push_back({32'h11, 32'h10, 32'hF, 32'hE});
                fill0(32'h11, 0);
            end
        join
        repeat (2) @(negedge clock);
        check("concurrent_fill_queue_empty", 128'(f0.size()), 128'd0);
        check("concurrent_send_queue_empty", 128'(q0.size()), 128'd0);

        // Reset during beat 2, then a request on the first edge after release.
        req0(1'b0, 4'h8, 32'h600, 128'h66666666_77777777_88888888_99999999);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("midrst_valid",  {127'b0, i0.bus_valid_out}, 128'd0);
        check("midrst_msg",    {124'b0, i0.bus_msg_out}, 128'd0);
        check("midrst_addr",   {96'b0, i0.bus_address_out}, 128'd0);
        check("midrst_data",   {96'b0, i0.bus_data_out}, 128'd0);
        check("midrst_offset", {125'b0, i0.active_offset}, 128'd0);
        check("midrst_line",   i0.line_data_out, 128'd0);
        check("midrst_beats_left", 128'(q0.size()), 128'd2);
        q0.delete();
        @(negedge clock);
        reset = 1'b1;
        i0.cache_valid_in = 1'b1; i0.cache_msg_in = 4'hA;
        i0.cache_address_in = 32'h700; i0.cache_data_in = 128'h1A1A1A1A_2B2B2B2B_3C3C3C3C_4D4D4D4D;
        push0(4'hA, 32'h700, 128'h1A1A1A1A_2B2B2B2B_3C3C3C3C_4D4D4D4D);
        #1;
        check("postrst_cache_ready", {127'b0, i0.cache_ready_out}, 128'd1);
        @(posedge clock); #1;
        i0.cache_valid_in = 1'b0;
        wait_done0(lat);
        check("postrst_latency", 128'(lat), 128'd4);
        check("postrst_queue_empty", 128'(q0.size()), 128'd0);

        // Single-beat instance: ack held off for one cycle, done one cycle after the ack.
        @(posedge clock); #1;
        i1.cache_valid_in = 1'b1; i1.cache_msg_in = 4'h3;
        i1.cache_address_in = 32'h104; i1.cache_data_in = 128'h000000D3_000000D2_000000D1_000000D0;
        push1(4'h3, 32'h104, 128'h000000D3_000000D2_000000D1_000000D0);
        @(negedge clock);
        check("dut1_cache_ready", {127'b0, i1.cache_ready_out}, 128'd1);
        @(posedge clock); #1;
        i1.cache_valid_in = 1'b0;
        @(negedge clock);
        check("dut1_valid_wait_ack", {127'b0, i1.bus_valid_out}, 128'd1);
        check("dut1_done_before_ack", {127'b0, i1.send_done}, 128'd0);
        @(posedge clock); #1;
        i1.bus_beat_ack = 1'b1;
        @(negedge clock);
        check("dut1_done_on_ack_cycle", {127'b0, i1.send_done}, 128'd0);
        @(posedge clock); #1;
        i1.bus_beat_ack = 1'b0;
        @(negedge clock);
        check("dut1_done_after_ack", {127'b0, i1.send_done}, 128'd1);
        check("dut1_queue_empty", 128'(q1.size()), 128'd0);

        @(posedge clock); #1;
        i1.bus_beat_valid_in = 1'b1;
        i1.bus_data_in = 128'hFEEDFACE_00112233_44556677_8899AABB;
        f1.push_back(128'hFEEDFACE_00112233_44556677_8899AABB);
        @(posedge clock); #1;
        i1.bus_beat_valid_in = 1'b0;
        repeat (2) @(negedge clock);
        check("dut1_fill_queue_empty", 128'(f1.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l1_beat_bus_interface.md
L1_BEAT_BUS_INTERFACE -- requirements
Module: l1_beat_bus_interface

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bits per word.
REQ-002 SHALL have parameter ADDRESS_BITS, default 32, meaning word-address width.
REQ-003 SHALL have parameter MSG_BITS, default 4, meaning coherence message width; message value 0 is NO_REQ.
REQ-004 SHALL have parameter CACHE_OFFSET_BITS, default 2, meaning log2 of words per cache line.
REQ-005 SHALL have parameter BUS_OFFSET_BITS, default 0, meaning log2 of words per bus beat; legal only if it is at most CACHE_OFFSET_BITS.
REQ-006 SHALL use derived values CACHE_WIDTH = DATA_WIDTH<<CACHE_OFFSET_BITS, BUS_WIDTH = DATA_WIDTH<<BUS_OFFSET_BITS, BEATS = 1<<(CACHE_OFFSET_BITS-BUS_OFFSET_BITS), BW = CACHE_OFFSET_BITS-BUS_OFFSET_BITS+1.
REQ-007 SHALL have one clock and an asynchronous, active-low reset, with ports as listed:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cache_valid_in  in  1  controller request valid.
- cache_msg_in / cache_address_in / cache_data_in  in  MSG_BITS / ADDRESS_BITS / CACHE_WIDTH  controller request.
- cache_ready_out  out  1  controller request accepted this cycle.
- snoop_valid_in  in  1  snooper response valid.
- snoop_msg_in / snoop_address_in / snoop_data_in  in  MSG_BITS / ADDRESS_BITS / CACHE_WIDTH  snooper response.
- snoop_ready_out  out  1  snooper response accepted this cycle.
- bus_grant  in  1  this cache owns the bus.
- bus_beat_ack  in  1  bus accepted the current beat.
- bus_valid_out  out  1  beat driven this cycle.
- bus_msg_out / bus_address_out / bus_data_out  out  MSG_BITS / ADDRESS_BITS / BUS_WIDTH  beat driven onto the bus.
- active_offset  out  BW  current send-beat index.
- send_done  out  1  one-cycle pulse after the final beat is acked.
- bus_beat_valid_in  in  1  incoming fill beat valid.
- bus_data_in  in  BUS_WIDTH  incoming fill beat.
- line_data_out  out  CACHE_WIDTH  assembled fill line.
- line_valid_out  out  1  one-cycle pulse when a fill line is complete.

Function
REQ-008 SHALL run a send FSM with states IDLE, SEND and DONE.
REQ-009 In IDLE, SHALL accept snoop when snoop_valid_in=1 (snoop has priority over cache), else cache when cache_valid_in=1; accepting means the matching ready_out is high combinationally for that one cycle.
REQ-010 On acceptance, SHALL latch msg, address with offset bits cleared, and line data, SHALL clear beat to 0, and SHALL go to SEND.
REQ-011 In SEND, bus_valid_out SHALL equal bus_grant.
REQ-012 In SEND, bus_msg_out SHALL be the latched msg.
REQ-013 In SEND, bus_address_out SHALL be the latched base OR (beat<<BUS_OFFSET_BITS).
REQ-014 In SEND, bus_data_out SHALL be latched line word group [beat*BUS_WIDTH +: BUS_WIDTH].
REQ-015 When bus_grant=1 and bus_beat_ack=1, beat SHALL increment; if beat==BEATS-1, the FSM SHALL go to DONE instead.
REQ-016 If bus_grant deasserts mid-transfer, the block SHALL hold beat and latched data, drive bus_valid_out=0, and resume on the same beat when grant returns.
REQ-017 A bus_beat_ack with bus_grant=0 SHALL be ignored.
REQ-018 DONE SHALL last one cycle: send_done=1, then go to IDLE; no request is accepted in DONE.
REQ-019 Outside SEND, bus_valid_out SHALL be 0, bus_msg_out NO_REQ, bus_address_out 0 and bus_data_out 0.
REQ-020 active_offset SHALL equal beat in SEND and 0 otherwise.
REQ-021 When BEATS=1, a transfer SHALL complete on the first granted ack.
REQ-022 The fill path SHALL run independently of the send FSM.
REQ-023 Each bus_beat_valid_in SHALL write bus_data_in into fill word group fcnt and increment fcnt, which wraps at BEATS.
REQ-024 On the beat where fcnt==BEATS-1, the next cycle SHALL have line_valid_out=1 and line_data_out equal to the full assembled line.
REQ-025 line_data_out SHALL hold its value until the next completed fill.
REQ-026 Send and fill activity in the same cycle SHALL not interact.

Reset
REQ-027 While reset=0, the FSM SHALL be IDLE and beat, fcnt, all latches and all outputs SHALL be 0, including mid-transfer, immediately and asynchronously.
REQ-028 After reset release, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-029 Defaults: cache req msg=3, addr=0x104, data=0xD3D2D1D0 per word; grant and ack held 1 -> 4 beats at addr 0x104..0x107, data D0..D3, active_offset 0..3, send_done on the 5th cycle.
REQ-030 snoop_valid_in and cache_valid_in both 1 in IDLE -> snoop_ready_out=1, cache_ready_out=0; the cache request is served after send_done.
REQ-031 Grant dropped after beat 1 for 3 cycles -> bus_valid_out=0 for those cycles, beat 2 resent with addr base+2, no beat skipped or duplicated.
REQ-032 BUS_OFFSET_BITS=CACHE_OFFSET_BITS=2 -> single 128-bit beat, send_done one cycle after the ack.
REQ-033 4 fill beats 0xA..0xD with gaps -> line_valid_out pulses once with line {D,C,B,A}; a 5th beat starts a new line without altering line_data_out.
REQ-034 reset=0 asserted during beat 2 -> outputs 0 immediately; after release, a new request starts at beat 0.
